mfp_ahb_gpio_irq_slave: RTL and testbench
=========================================

MFP_AHB_GPIO_IRQ_SLAVE -- requirements
Module: mfp_ahb_gpio_irq_slave

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 16, number of bidirectional GPIO channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-003 SHALL have port HCLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports HADDR in 32, HSIZE in 3, HTRANS in 2, HWRITE in 1, HSEL in 1, HWDATA in 32: AHB-Lite slave inputs.
REQ-006 SHALL have ports HRDATA out 32, HREADY out 1, HRESP out 1: AHB-Lite slave outputs.
REQ-007 SHALL have port GPIO_In  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-008 SHALL have port GPIO_Out  output  GPIO_WIDTH  pin output values.
REQ-009 SHALL have port GPIO_OutEn  output  GPIO_WIDTH  per-pin output enable, 1 = drive.
REQ-010 SHALL have port IRQ  output  1  level interrupt, OR of pending enabled status.

Function
REQ-011 HREADY SHALL be constant 1 (zero wait states); HRESP SHALL be constant 0.
REQ-012 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY; HADDR[5:2], HWRITE, byte mask registered into data-phase registers.
REQ-013 Byte mask SHALL derive from HSIZE/HADDR[1:0], little-endian: byte -> one lane, halfword -> lanes {1:0} or {3:2}, word -> all four; only masked lanes update.
REQ-014 Register map (word offset): 0 DOUT RW, 1 DIR RW, 2 DIN RO, 3 RISE_EN RW, 4 FALL_EN RW, 5 STATUS R/W1C, 6 DOUT_SET WO, 7 DOUT_CLR WO; offsets 8..15 read 0, writes ignored.
REQ-015 Write data SHALL be applied at the end of the data-phase cycle using the registered address.
REQ-016 HRDATA SHALL be driven in the data phase from the registered read address; a read in the cycle after a write to the same register SHALL return the new value.
REQ-017 Bits [31:GPIO_WIDTH] SHALL read 0 and be ignored on write; offsets 6, 7 SHALL read 0.
REQ-018 DOUT_SET write SHALL set DOUT bits where wdata=1; DOUT_CLR SHALL clear DOUT bits where wdata=1; other bits unchanged.
REQ-019 GPIO_Out SHALL equal DOUT; GPIO_OutEn SHALL equal DIR, both registered.
REQ-020 GPIO_In SHALL pass a SYNC_STAGES flop synchroniser; DIN SHALL show synchronised value, readable SYNC_STAGES cycles after pin change.
REQ-021 Edge detector SHALL compare synchronised value with its one-cycle-delayed copy; rising edge sets STATUS[i] if RISE_EN[i], falling edge if FALL_EN[i], one cycle after DIN changes.
REQ-022 Edge detection SHALL operate regardless of DIR.
REQ-023 STATUS write SHALL clear bits where wdata=1; when set and clear hit the same bit in one cycle, set SHALL win.
REQ-024 Clearing RISE_EN/FALL_EN SHALL not clear STATUS.
REQ-025 IRQ SHALL equal OR of STATUS[GPIO_WIDTH-1:0], combinational from STATUS register.
REQ-026 Transfers with HSEL=0 or HTRANS IDLE/BUSY SHALL not alter any register.

Reset
REQ-027 HRESET=1 SHALL asynchronously clear DOUT, DIR, RISE_EN, FALL_EN, STATUS, synchroniser and edge flops, data-phase registers, HRDATA; GPIO_Out, GPIO_OutEn, IRQ SHALL be 0.
REQ-028 Reset asserted mid data phase SHALL drop the pending write; first access after release SHALL behave as fresh address phase.
REQ-029 After reset release no edge SHALL be flagged for pins already high at release until a genuine transition occurs (delayed copy also reset to 0 but RISE_EN=0 masks it).

Verification
REQ-030 Word write 0x0000_A5A5 to offset 0, DIR=0xFFFF -> GPIO_Out=0xA5A5, GPIO_OutEn=0xFFFF next cycle; read offset 0 returns 0x0000A5A5.
REQ-031 Byte write 0x0000_3C00 to HADDR[1:0]=1 at offset 0 with DOUT=0xA5A5 -> DOUT=0x3CA5; DOUT_SET 0x0003 then DOUT_CLR 0x0021 -> 0x3C86.
REQ-032 RISE_EN=0x0001, GPIO_In[0] 0->1 -> DIN[0]=1 after 2 cycles, STATUS=0x0001 and IRQ=1 after 3; write 0x1 to STATUS -> IRQ=0.
REQ-033 W1C to STATUS[0] in same cycle as new rising edge on pin 0 -> STATUS[0] stays 1, IRQ stays 1.
REQ-034 GPIO_WIDTH=8: write 0xFFFF_FFFF to DOUT -> read 0x000000FF; read offset 12 -> 0.
REQ-035 Assert HRESET during write data phase to DIR -> DIR=0, IRQ=0, GPIO_Out=0, HRDATA=0 immediately, without waiting for HCLK.

Source files
------------

// File: rtl/mfp_ahb_gpio_irq_slave_if.sv
// AHB-Lite slave bus bundle for the GPIO/IRQ peripheral.
// The master modport drives the address/control/write data; the slave returns read data and status.
interface mfp_ahb_gpio_irq_slave_if;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HSIZE, HTRANS, HWRITE, HSEL, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HSIZE, HTRANS, HWRITE, HSEL, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_gpio_irq_slave.sv
// Zero-wait-state AHB-Lite GPIO block with per-pin output enables,
// synchronised inputs and rise/fall edge interrupts latched in a W1C status register.
module mfp_ahb_gpio_irq_slave #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  mfp_ahb_gpio_irq_slave_if.slave bus,
  input  logic [GPIO_WIDTH-1:0] GPIO_In,
  output logic [GPIO_WIDTH-1:0] GPIO_Out,
  output logic [GPIO_WIDTH-1:0] GPIO_OutEn,
  output logic                  IRQ
);

  localparam logic [3:0] OFF_DOUT     = 4'd0;
  localparam logic [3:0] OFF_DIR      = 4'd1;
  localparam logic [3:0] OFF_DIN      = 4'd2;
  localparam logic [3:0] OFF_RISE_EN  = 4'd3;
  localparam logic [3:0] OFF_FALL_EN  = 4'd4;
  localparam logic [3:0] OFF_STATUS   = 4'd5;
  localparam logic [3:0] OFF_DOUT_SET = 4'd6;
  localparam logic [3:0] OFF_DOUT_CLR = 4'd7;

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] din;
  logic [GPIO_WIDTH-1:0] din_d;

  logic [GPIO_WIDTH-1:0] dout, dir, rise_en, fall_en, status;
  logic [GPIO_WIDTH-1:0] dout_nxt, dir_nxt, rise_en_nxt, fall_en_nxt, status_nxt;
  logic [GPIO_WIDTH-1:0] status_clr, edge_set;
  logic [GPIO_WIDTH-1:0] wmask, wbits;
  logic [GPIO_WIDTH-1:0] rdata_w;
  logic [31:0]           rdata;

  logic       dp_valid;
  logic       dp_write;
  logic [3:0] dp_addr;
  logic [3:0] dp_mask;
  logic [3:0] addr_mask;
  logic       accept;
  logic       wr_en;
  logic       unused_bus;

  assign bus.HREADY = 1'b1;
  assign bus.HRESP  = 1'b0;
  assign unused_bus = ^{bus.HADDR[31:6], bus.HTRANS[0], bus.HWDATA};

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign wr_en  = dp_valid & dp_write;

  always_comb begin
    addr_mask = 4'b1111;
    case (bus.HSIZE)
      3'b000:  addr_mask = 4'b0001 << bus.HADDR[1:0];
      3'b001:  addr_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_mask  <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= bus.HWRITE;
        dp_addr  <= bus.HADDR[5:2];
        dp_mask  <= addr_mask;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      din_d <= '0;
    end else begin
      sync_q[0] <= GPIO_In;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      din_d <= din;
    end
  end

  assign din      = sync_q[SYNC_STAGES-1];
  assign edge_set = (din & ~din_d & rise_en) | (~din & din_d & fall_en);

  // Expand the byte-lane mask onto the implemented pin bits
  always_comb begin
    wmask = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) wmask[i] = dp_mask[i >> 3];
    wbits = bus.HWDATA[GPIO_WIDTH-1:0] & wmask;
  end

  always_comb begin
    dout_nxt    = dout;
    dir_nxt     = dir;
    rise_en_nxt = rise_en;
    fall_en_nxt = fall_en;
    status_clr  = '0;
    if (wr_en) begin
      case (dp_addr)
        OFF_DOUT:     dout_nxt    = (dout & ~wmask) | wbits;
        OFF_DIR:      dir_nxt     = (dir & ~wmask) | wbits;
        OFF_RISE_EN:  rise_en_nxt = (rise_en & ~wmask) | wbits;
        OFF_FALL_EN:  fall_en_nxt = (fall_en & ~wmask) | wbits;
        OFF_STATUS:   status_clr  = wbits;
        OFF_DOUT_SET: dout_nxt    = dout | wbits;
        OFF_DOUT_CLR: dout_nxt    = dout & ~wbits;
        default:      ;
      endcase
    end
    // A new edge in the same cycle as a W1C keeps the flag set
    status_nxt = (status & ~status_clr) | edge_set;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dout    <= '0;
      dir     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      dout    <= dout_nxt;
      dir     <= dir_nxt;
      rise_en <= rise_en_nxt;
      fall_en <= fall_en_nxt;
      status  <= status_nxt;
    end
  end

  always_comb begin
    rdata_w = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        OFF_DOUT:    rdata_w = dout;
        OFF_DIR:     rdata_w = dir;
        OFF_DIN:     rdata_w = din;
        OFF_RISE_EN: rdata_w = rise_en;
        OFF_FALL_EN: rdata_w = fall_en;
        OFF_STATUS:  rdata_w = status;
        default:     rdata_w = '0;
      endcase
    end
    rdata                 = '0;
    rdata[GPIO_WIDTH-1:0] = rdata_w;
  end

  assign bus.HRDATA = rdata;
  assign GPIO_Out   = dout;
  assign GPIO_OutEn = dir;
  assign IRQ        = |status;

endmodule

// File: tb/tb_mfp_ahb_gpio_irq_slave.sv
// Directed bench: a 16-pin and an 8-pin instance share one AHB stimulus stream.
module tb_mfp_ahb_gpio_irq_slave;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hsel;
  logic [31:0] hwdata;
  logic [15:0] gpio_in;

  logic [15:0] out16, oen16;
  logic [7:0]  out8, oen8;
  logic        irq16, irq8;

  int checks = 0;
  int errors = 0;

  logic [31:0] d16, d8;

  mfp_ahb_gpio_irq_slave_if bus16 ();
  mfp_ahb_gpio_irq_slave_if bus8 ();

  assign bus16.HADDR  = haddr;
  assign bus16.HSIZE  = hsize;
  assign bus16.HTRANS = htrans;
  assign bus16.HWRITE = hwrite;
  assign bus16.HSEL   = hsel;
  assign bus16.HWDATA = hwdata;
  assign bus8.HADDR   = haddr;
  assign bus8.HSIZE   = hsize;
  assign bus8.HTRANS  = htrans;
  assign bus8.HWRITE  = hwrite;
  assign bus8.HSEL    = hsel;
  assign bus8.HWDATA  = hwdata;

  mfp_ahb_gpio_irq_slave #(.GPIO_WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus16.slave),
    .GPIO_In(gpio_in), .GPIO_Out(out16), .GPIO_OutEn(oen16), .IRQ(irq16)
  );

  mfp_ahb_gpio_irq_slave #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus8.slave),
    .GPIO_In(gpio_in[7:0]), .GPIO_Out(out8), .GPIO_OutEn(oen8), .IRQ(irq8)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    haddr = addr; hsize = size; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    step(1);
    htrans = 2'b00; hsel = 1'b0; hwrite = 1'b0; hwdata = data;
    step(1);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] r16, output logic [31:0] r8);
    haddr = addr; hsize = 3'b010; hwrite = 1'b0; htrans = 2'b10; hsel = 1'b1;
    step(1);
    htrans = 2'b00; hsel = 1'b0;
    r16 = bus16.HRDATA;
    r8  = bus8.HRDATA;
    step(1);
  endtask

  initial begin
    HRESET = 1'b1;
    haddr = '0; hsize = 3'b010; htrans = 2'b00; hwrite = 1'b0; hsel = 1'b0; hwdata = '0;
    gpio_in = '0;
    step(3);
    check("rst_gpio_out", {16'h0, out16}, 32'h0);
    check("rst_gpio_oen", {16'h0, oen16}, 32'h0);
    check("rst_irq", {31'h0, irq16}, 32'h0);
    check("rst_hrdata", bus16.HRDATA, 32'h0);
    HRESET = 1'b0;
    step(2);

    // Word writes to DOUT and DIR
    ahb_write(32'h0, 3'b010, 32'h0000_A5A5);
    ahb_write(32'h4, 3'b010, 32'h0000_FFFF);
    check("word_gpio_out", {16'h0, out16}, 32'h0000_A5A5);
    check("word_gpio_oen", {16'h0, oen16}, 32'h0000_FFFF);
    ahb_read(32'h0, d16, d8);
    check("word_read_dout", d16, 32'h0000_A5A5);
    check("w8_read_dout", d8, 32'h0000_00A5);

    // Sub-word lanes
    ahb_write(32'h1, 3'b000, 32'h0000_3C00);
    ahb_read(32'h0, d16, d8);
    check("byte_lane1", d16, 32'h0000_3CA5);
    check("w8_byte_lane1", d8, 32'h0000_00A5);
    ahb_write(32'h2, 3'b001, 32'h1234_0000);
    check("half_upper_ignored", {16'h0, out16}, 32'h0000_3CA5);

    // Set / clear aliases
    ahb_write(32'h18, 3'b010, 32'h0000_0003);
    check("dout_set", {16'h0, out16}, 32'h0000_3CA7);
    ahb_write(32'h1C, 3'b010, 32'h0000_0021);
    check("dout_clr", {16'h0, out16}, 32'h0000_3C86);
    ahb_read(32'h18, d16, d8);
    check("read_set_zero", d16, 32'h0);

    // IDLE and unselected transfers must not write
    haddr = 32'h0; hsize = 3'b010; hwrite = 1'b1; htrans = 2'b00; hsel = 1'b1;
    step(1);
    hsel = 1'b0; hwrite = 1'b0; hwdata = 32'h0;
    step(1);
    check("idle_no_write", {16'h0, out16}, 32'h0000_3C86);
    haddr = 32'h0; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b0;
    step(1);
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0;
    step(1);
    check("hsel0_no_write", {16'h0, out16}, 32'h0000_3C86);

    // Back-to-back write then read of RISE_EN
    haddr = 32'hC; hsize = 3'b010; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    step(1);
    hwdata = 32'h0000_0001; hwrite = 1'b0;
    step(1);
    htrans = 2'b00; hsel = 1'b0;
    check("raw_rise_en", bus16.HRDATA, 32'h0000_0001);
    step(1);

    // Rising edge on pin 0: DIN after 2 edges, STATUS/IRQ after 3
    gpio_in[0] = 1'b1;
    step(2);
    check("edge_irq_not_yet", {31'h0, irq16}, 32'h0);
    step(1);
    check("edge_irq_set", {31'h0, irq16}, 32'h1);
    ahb_read(32'h8, d16, d8);
    check("din_read", d16, 32'h0000_0001);
    ahb_read(32'h14, d16, d8);
    check("status_read", d16, 32'h0000_0001);
    ahb_write(32'h14, 3'b010, 32'h0000_0001);
    check("w1c_irq_clear", {31'h0, irq16}, 32'h0);

    // W1C landing on the same edge as a new rising edge
    gpio_in[0] = 1'b0;
    step(4);
    check("fall_masked", {31'h0, irq16}, 32'h0);
    gpio_in[0] = 1'b1;
    step(1);
    ahb_write(32'h14, 3'b010, 32'h0000_0001);
    check("set_wins_irq", {31'h0, irq16}, 32'h1);
    ahb_read(32'h14, d16, d8);
    check("set_wins_status", d16, 32'h0000_0001);
    ahb_write(32'h14, 3'b010, 32'h0000_0001);
    check("status_cleared", {31'h0, irq16}, 32'h0);

    // Falling-edge enable on pin 1; disabling it keeps the flag
    ahb_write(32'h10, 3'b010, 32'h0000_0002);
    gpio_in[1] = 1'b1;
    step(4);
    check("rise_pin1_masked", {31'h0, irq16}, 32'h0);
    gpio_in[1] = 1'b0;
    step(4);
    check("fall_pin1_irq", {31'h0, irq16}, 32'h1);
    ahb_write(32'h10, 3'b010, 32'h0000_0000);
    ahb_read(32'h14, d16, d8);
    check("status_kept", d16, 32'h0000_0002);

    // Width truncation and unmapped offsets
    ahb_write(32'h0, 3'b010, 32'hFFFF_FFFF);
    ahb_read(32'h0, d16, d8);
    check("w8_dout_trunc", d8, 32'h0000_00FF);
    check("w16_dout_trunc", d16, 32'h0000_FFFF);
    ahb_read(32'h30, d16, d8);
    check("w8_off12", d8, 32'h0);
    check("w16_off12", d16, 32'h0);

    // Asynchronous reset in the middle of a DIR write data phase
    check("pre_rst_irq", {31'h0, irq16}, 32'h1);
    haddr = 32'h4; hsize = 3'b010; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    step(1);
    htrans = 2'b00; hsel = 1'b0; hwrite = 1'b0; hwdata = 32'h0000_1234;
    #2;
    HRESET = 1'b1;
    #1;
    check("async_rst_oen", {16'h0, oen16}, 32'h0);
    check("async_rst_out", {16'h0, out16}, 32'h0);
    check("async_rst_irq", {31'h0, irq16}, 32'h0);
    check("async_rst_hrdata", bus16.HRDATA, 32'h0);
    step(2);
    HRESET = 1'b0;
    step(2);
    check("dropped_write", {16'h0, oen16}, 32'h0);
    ahb_write(32'h4, 3'b010, 32'h0000_00F0);
    check("post_rst_write", {16'h0, oen16}, 32'h0000_00F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
